// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// dram_port_arbiter : shares one DRAM port between IF and data requesters
// Revision: 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_din,
  input  logic [2:0]  d_rd_ctrl,
  input  logic [2:0]  d_wr_ctrl,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        d_err,
  output logic        stall_if,
  output logic        stall_d,
  output logic        dram_req,
  output logic [63:0] dram_addr,
  output logic [63:0] dram_din,
  output logic [2:0]  dram_rd_ctrl,
  output logic [2:0]  dram_wr_ctrl,
  input  logic        dram_ready,
  input  logic        dram_rvalid,
  input  logic [63:0] dram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0] IF_RD_CTRL = 3'b011;

  state_t      state;
  logic        owner;        // 0 = IF, 1 = data
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;

  logic        d_valid;
  logic        data_wins;
  logic        in_flight;
  logic        rsp_ok;
  logic        tmo_abort;
  logic        finish;

  // A data request with no load/store control is not a real request.
  assign d_valid   = d_req & ((|d_rd_ctrl) | (|d_wr_ctrl));
  assign data_wins = d_valid & ~(if_req & (starve_cnt == STARVE_MAX));
  assign in_flight = (state == REQ) | (state == RSP);

  // A response in the timeout cycle still completes normally.
  assign rsp_ok    = (state == RSP) & dram_rvalid;
  assign tmo_abort = (tmo_cnt == TMO_LAST) &
                     (((state == REQ) & ~dram_ready) | ((state == RSP) & ~dram_rvalid));
  assign finish    = rsp_ok | tmo_abort;

  assign stall_if = reset & ((if_req & ~(~owner & (state == DONE))) | (~owner & in_flight));
  assign stall_d  = reset & ((d_valid & ~(owner & (state == DONE))) | (owner & in_flight));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      starve_cnt   <= 4'd0;
      tmo_cnt      <= 8'd0;
      if_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      if_rdata     <= 64'd0;
      if_err       <= 1'b0;
      d_gnt        <= 1'b0;
      d_rvalid     <= 1'b0;
      d_rdata      <= 64'd0;
      d_err        <= 1'b0;
      dram_req     <= 1'b0;
      dram_addr    <= 64'd0;
      dram_din     <= 64'd0;
      dram_rd_ctrl <= 3'd0;
      dram_wr_ctrl <= 3'd0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | d_valid) begin
            state    <= REQ;
            dram_req <= 1'b1;
            tmo_cnt  <= 8'd0;
            owner    <= data_wins;
            if (data_wins) begin
              d_gnt        <= 1'b1;
              dram_addr    <= d_addr;
              dram_din     <= d_din;
              dram_rd_ctrl <= d_rd_ctrl;
              dram_wr_ctrl <= d_wr_ctrl;
              if (if_req && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
              if_gnt       <= 1'b1;
              dram_addr    <= if_addr;
              dram_din     <= 64'd0;
              dram_rd_ctrl <= IF_RD_CTRL;
              dram_wr_ctrl <= 3'd0;
              starve_cnt   <= 4'd0;
            end
          end
        end
        REQ, RSP: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (finish) begin
            state    <= DONE;
            dram_req <= 1'b0;
            if (owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= rsp_ok ? dram_dout : 64'd0;
              d_err    <= ~rsp_ok;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= rsp_ok ? dram_dout : 64'd0;
              if_err    <= ~rsp_ok;
            end
          end else if ((state == REQ) && dram_ready) begin
            state    <= RSP;
            dram_req <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// Randomized bench for dram_port_arbiter; a transaction-level model predicts
// every output each cycle.
module tb_dram_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [63:0] if_rdata;
  logic        d_req = 1'b0;
  logic [63:0] d_addr = '0, d_din = '0;
  logic [2:0]  d_rd_ctrl = '0, d_wr_ctrl = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [63:0] d_rdata;
  logic        stall_if, stall_d, dram_req;
  logic [63:0] dram_addr, dram_din;
  logic [2:0]  dram_rd_ctrl, dram_wr_ctrl;
  logic        dram_ready = 1'b0, dram_rvalid = 1'b0;
  logic [63:0] dram_dout = '0;

  dram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_din(d_din), .d_rd_ctrl(d_rd_ctrl),
    .d_wr_ctrl(d_wr_ctrl), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err), .stall_if(stall_if), .stall_d(stall_d),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_rd_ctrl(dram_rd_ctrl), .dram_wr_ctrl(dram_wr_ctrl),
    .dram_ready(dram_ready), .dram_rvalid(dram_rvalid), .dram_dout(dram_dout)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer described by its
  // owner, its age in cycles, whether DRAM accepted it and whether it is
  // in its response-delivery cycle.
  bit          m_busy, m_owner_d, m_accepted, m_finishing;
  int          m_age, m_starve;
  logic [63:0] m_addr, m_din, m_if_rdata, m_d_rdata;
  logic [2:0]  m_rd, m_wr;
  bit          m_if_err, m_d_err;

  int p_if, p_d, p_null, p_ready, p_rvalid, p_reset;

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_accepted = 0; m_finishing = 0;
    m_age = 0; m_starve = 0;
    m_addr = '0; m_din = '0; m_rd = '0; m_wr = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_if_err = 0; m_d_err = 0;
  endtask

  function automatic bit data_valid();
    return d_req && (d_rd_ctrl != 3'd0 || d_wr_ctrl != 3'd0);
  endfunction

  task automatic finish_txn(input logic [63:0] data, input bit err);
    m_finishing = 1;
    if (m_owner_d) begin m_d_rdata = data; m_d_err = err; end
    else begin m_if_rdata = data; m_if_err = err; end
  endtask

  task automatic model_step();
    bit dv, if_wins;
    dv = data_valid();
    if (!m_busy) begin
      if (if_req || dv) begin
        if_wins = if_req && (!dv || m_starve >= STARVE_LIMIT);
        m_busy = 1; m_age = 0; m_accepted = 0; m_finishing = 0;
        m_owner_d = !if_wins;
        if (if_wins) begin
          m_starve = 0;
          m_addr = if_addr; m_din = '0; m_rd = 3'b011; m_wr = 3'd0;
        end else begin
          if (if_req && m_starve < STARVE_LIMIT) m_starve++;
          m_addr = d_addr; m_din = d_din; m_rd = d_rd_ctrl; m_wr = d_wr_ctrl;
        end
      end
    end else if (m_finishing) begin
      m_busy = 0; m_finishing = 0;
    end else begin
      if (m_accepted && dram_rvalid) finish_txn(dram_dout, 0);
      else if (m_age == TIMEOUT - 1) finish_txn('0, 1);
      else if (!m_accepted && dram_ready) m_accepted = 1;
      m_age++;
    end
  endtask

  task automatic check_cycle();
    bit dv, e_req, e_sif, e_sd;
    dv = data_valid();
    e_req = m_busy && !m_accepted && !m_finishing;
    e_sif = reset && ((if_req && !(m_finishing && !m_owner_d)) ||
                      (m_busy && !m_finishing && !m_owner_d));
    e_sd  = reset && ((dv && !(m_finishing && m_owner_d)) ||
                      (m_busy && !m_finishing && m_owner_d));
    check("dram_req",  64'(dram_req),  64'(e_req));
    check("if_gnt",    64'(if_gnt),    64'(m_busy && m_age == 0 && !m_owner_d));
    check("d_gnt",     64'(d_gnt),     64'(m_busy && m_age == 0 && m_owner_d));
    check("if_rvalid", 64'(if_rvalid), 64'(m_finishing && !m_owner_d));
    check("d_rvalid",  64'(d_rvalid),  64'(m_finishing && m_owner_d));
    check("stall_if",  64'(stall_if),  64'(e_sif));
    check("stall_d",   64'(stall_d),   64'(e_sd));
    check("dram_addr", dram_addr, m_addr);
    check("dram_din",  dram_din,  m_din);
    check("dram_rd",   64'(dram_rd_ctrl), 64'(m_rd));
    check("dram_wr",   64'(dram_wr_ctrl), 64'(m_wr));
    check("if_rdata",  if_rdata, m_if_rdata);
    check("if_err",    64'(if_err), 64'(m_if_err));
    check("d_rdata",   d_rdata,  m_d_rdata);
    check("d_err",     64'(d_err),  64'(m_d_err));
  endtask

  task automatic drive();
    if_req  = pct(p_if);
    if_addr = rnd64();
    d_req   = pct(p_d);
    d_addr  = rnd64();
    d_din   = rnd64();
    if (pct(p_null)) begin
      d_rd_ctrl = 3'd0; d_wr_ctrl = 3'd0;
    end else if (pct(50)) begin
      d_rd_ctrl = 3'($urandom_range(1, 7)); d_wr_ctrl = 3'd0;
    end else begin
      d_rd_ctrl = 3'd0; d_wr_ctrl = 3'($urandom_range(1, 7));
    end
    dram_ready  = pct(p_ready);
    dram_rvalid = pct(p_rvalid);
    dram_dout   = rnd64();
    // Keep the DRAM quiet in the last REQ cycle so the abort point is unambiguous.
    if (m_busy && !m_accepted && !m_finishing && m_age == TIMEOUT - 1) begin
      dram_ready = 1'b0; dram_rvalid = 1'b0;
    end
    if (!reset) reset = 1'b1;
    else reset = !pct(p_reset);
  endtask

  // Phase table: p_if, p_d, p_null, p_ready, p_rvalid, p_reset, cycles
  int phases [7][7] = '{
    '{ 60,  60,  0, 100, 100, 0, 200},   // minimum-latency DRAM
    '{100, 100,  0, 100, 100, 0, 200},   // continuous contention
    '{ 50,  50, 25,  50,  50, 0, 300},   // mixed traffic incl. null requests
    '{ 60,  60, 10,   0,   0, 0, 150},   // DRAM never accepts
    '{ 60,  60, 10, 100,   0, 0, 100},   // DRAM accepts, never answers
    '{ 50,  50, 20,  60,  50, 4, 400},   // random resets
    '{ 70,  70, 10,  20,  25, 0, 300}    // slow DRAM
  };

  initial begin
    model_reset();
    p_reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle();
    for (int ph = 0; ph < 7; ph++) begin
      p_if = phases[ph][0]; p_d = phases[ph][1]; p_null = phases[ph][2];
      p_ready = phases[ph][3]; p_rvalid = phases[ph][4]; p_reset = phases[ph][5];
      for (int c = 0; c < phases[ph][6]; c++) begin
        @(posedge clk);
        #1;
        drive();
        if (!reset) model_reset();
        @(negedge clk);
        check_cycle();
        if (reset) model_step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
